// File: rtl/opcode_wb_stage5.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : opcode_wb_stage5                                                |
// | Desc     : Stage-5 memory/writeback: load/store handshake, RF write port,  |
// |            upstream stall, retire counter and sticky error status.         |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module opcode_wb_stage5 #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [19:0]       opcode_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       retired_cnt,
  output logic              timeout_err,
  output logic              illegal_err
);

  localparam int c_CNT_W = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [19:0] c_NOP_WORD = 20'h00800;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_wait_cnt;
  logic [c_CNT_W-1:0]  w_wait_cnt_nxt;

  logic [19:0]         r_opcode;
  logic [REG_AW-1:0]   r_dest;
  logic [DATA_W-1:0]   r_alu;
  logic [DATA_W-1:0]   r_sdata;

  logic w_is_load, w_is_store, w_is_mem, w_is_reg, w_is_nop, w_illegal;
  logic w_timeout, w_done, w_retire;

  assign w_is_load  = r_opcode[2] & r_opcode[16];
  assign w_is_store = r_opcode[17];
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_is_reg   = r_opcode[16] & ~w_is_load;
  assign w_is_nop   = (r_opcode == c_NOP_WORD) || (r_opcode == 20'h0);
  assign w_illegal  = ~(w_is_mem | w_is_reg | w_is_nop);

  // Memory ops finish on ack or timeout; everything else finishes immediately.
  assign w_done    = w_is_mem ? (mem_ack | w_timeout) : 1'b1;
  assign w_retire  = w_done & (w_is_reg | (w_is_mem & ~w_timeout));
  assign stall_out = w_is_mem & ~w_done;

  assign mem_req   = w_is_mem;
  assign mem_we    = w_is_store;
  assign mem_addr  = r_alu;
  assign mem_wdata = w_is_store ? r_sdata : '0;

  assign rf_we     = w_is_reg | (w_is_load & mem_ack);
  assign rf_waddr  = r_dest;
  assign rf_wdata  = w_is_load ? mem_rdata : r_alu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opcode <= '0;
      r_dest   <= '0;
      r_alu    <= '0;
      r_sdata  <= '0;
    end else if (!stall_out) begin
      r_opcode <= opcode_in;
      r_dest   <= dest_in;
      r_alu    <= alu_in;
      r_sdata  <= store_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout      = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_is_mem && !mem_ack) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = c_CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!w_is_mem || mem_ack) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == c_TO_LAST) begin
          w_timeout      = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      timeout_err <= 1'b0;
      illegal_err <= 1'b0;
    end else begin
      if (w_retire)  retired_cnt <= retired_cnt + 16'd1;
      if (w_timeout) timeout_err <= 1'b1;
      if (w_illegal) illegal_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opcode_wb_stage5.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_opcode_wb_stage5                                             |
// | Desc     : Directed self-checking bench for opcode_wb_stage5.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_opcode_wb_stage5;

  logic        clk;
  logic        rst;
  logic [19:0] opcode_in;
  logic [4:0]  dest_in;
  logic [31:0] alu_in;
  logic [31:0] store_data_in;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] retired_cnt;
  logic        timeout_err;
  logic        illegal_err;

  int n_cmp = 0;
  int n_mis = 0;

  opcode_wb_stage5 #(.DATA_W(32), .REG_AW(5), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode_in     (opcode_in),
    .dest_in       (dest_in),
    .alu_in        (alu_in),
    .store_data_in (store_data_in),
    .stall_out     (stall_out),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .retired_cnt   (retired_cnt),
    .timeout_err   (timeout_err),
    .illegal_err   (illegal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] op, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] s);
    opcode_in     = op;
    dest_in       = d;
    alu_in        = a;
    store_data_in = s;
  endtask

  initial begin
    int n_req;
    int n_stall;
    int n_rfwe;

    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    tick();
    #2;
    check_eq("rst_stall",   32'(stall_out),   32'd0);
    check_eq("rst_mem_req", 32'(mem_req),     32'd0);
    check_eq("rst_rf_we",   32'(rf_we),       32'd0);
    check_eq("rst_retired", 32'(retired_cnt), 32'd0);
    check_eq("rst_errs",    {30'd0, timeout_err, illegal_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ADD: register write one cycle after capture
    drive(20'h10001, 5'd3, 32'h55, 32'h0);
    tick();
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    #2;
    check_eq("add_rf_we",    32'(rf_we),     32'd1);
    check_eq("add_rf_waddr", 32'(rf_waddr),  32'd3);
    check_eq("add_rf_wdata", rf_wdata,       32'h55);
    check_eq("add_stall",    32'(stall_out), 32'd0);
    check_eq("add_mem_req",  32'(mem_req),   32'd0);
    tick();
    #2;
    check_eq("add_retired", 32'(retired_cnt), 32'd1);
    check_eq("add_rf_we_off", 32'(rf_we),     32'd0);

    // LOAD: ack arrives on the fourth request cycle
    drive(20'h10004, 5'd5, 32'h100, 32'h0);
    tick();
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    n_req = 0; n_stall = 0; n_rfwe = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD;
      end
      #2;
      if (mem_req) n_req++;
      if (stall_out) n_stall++;
      if (rf_we) n_rfwe++;
      check_eq("ld_addr", mem_addr, 32'h100);
      check_eq("ld_we",   32'(mem_we), 32'd0);
      if (i == 3) begin
        check_eq("ld_rf_wdata", rf_wdata,      32'hDEAD);
        check_eq("ld_rf_waddr", 32'(rf_waddr), 32'd5);
      end
      tick();
    end
    mem_ack = 1'b0;
    mem_rdata = '0;
    #2;
    check_eq("ld_req_cycles",   32'(n_req),   32'd4);
    check_eq("ld_stall_cycles", 32'(n_stall), 32'd3);
    check_eq("ld_rf_pulses",    32'(n_rfwe),  32'd1);
    check_eq("ld_retired",      32'(retired_cnt), 32'd2);
    check_eq("ld_req_drop",     32'(mem_req), 32'd0);

    // STORE acknowledged in its first cycle
    drive(20'h20008, 5'd9, 32'h200, 32'hBEEF);
    tick();
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    mem_ack = 1'b1;
    #2;
    check_eq("st_req",   32'(mem_req),   32'd1);
    check_eq("st_we",    32'(mem_we),    32'd1);
    check_eq("st_wdata", mem_wdata,      32'hBEEF);
    check_eq("st_addr",  mem_addr,       32'h200);
    check_eq("st_stall", 32'(stall_out), 32'd0);
    check_eq("st_rf_we", 32'(rf_we),     32'd0);
    tick();
    // bubble in stage: the ack held high must be ignored
    #2;
    check_eq("st_retired",    32'(retired_cnt), 32'd3);
    check_eq("idle_ack_rfwe", 32'(rf_we),       32'd0);
    check_eq("idle_wdata",    mem_wdata,        32'h0);
    tick();
    mem_ack = 1'b0;
    #2;
    check_eq("idle_ack_retired", 32'(retired_cnt), 32'd3);

    // STORE never acknowledged; an ADD waits behind it
    drive(20'h20008, 5'd1, 32'h300, 32'h1234);
    tick();
    drive(20'h10001, 5'd7, 32'h77, 32'h0);
    n_req = 0; n_rfwe = 0;
    #2;
    while (mem_req && n_req < 40) begin
      n_req++;
      if (rf_we) n_rfwe++;
      if (n_req == 15) check_eq("to_err_before", 32'(timeout_err), 32'd0);
      tick();
      #2;
    end
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    check_eq("to_req_cycles", 32'(n_req),       32'd16);
    check_eq("to_rf_we",      32'(n_rfwe),      32'd0);
    check_eq("to_err",        32'(timeout_err), 32'd1);
    check_eq("to_retired",    32'(retired_cnt), 32'd3);
    check_eq("to_next_rf_we", 32'(rf_we),       32'd1);
    check_eq("to_next_wdata", rf_wdata,         32'h77);
    check_eq("to_next_stall", 32'(stall_out),   32'd0);
    tick();
    #2;
    check_eq("to_next_retired", 32'(retired_cnt), 32'd4);

    // NOP then an illegal word with no control bits
    drive(20'h00800, 5'd2, 32'h11, 32'h22);
    tick();
    drive(20'h00001, 5'd4, 32'h33, 32'h44);
    #2;
    check_eq("nop_act", {29'd0, rf_we, mem_req, stall_out}, 32'd0);
    check_eq("nop_ill", 32'(illegal_err), 32'd0);
    tick();
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    #2;
    check_eq("ill_act", {29'd0, rf_we, mem_req, stall_out}, 32'd0);
    tick();
    #2;
    check_eq("ill_err",     32'(illegal_err), 32'd1);
    check_eq("ill_retired", 32'(retired_cnt), 32'd4);

    // Reset asserted while a LOAD is waiting for memory
    drive(20'h10004, 5'd6, 32'h400, 32'h0);
    tick();
    drive(20'h0, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    #2;
    check_eq("rw_stall_pre", 32'(stall_out), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rw_req",     32'(mem_req),     32'd0);
    check_eq("rw_stall",   32'(stall_out),   32'd0);
    check_eq("rw_rf_we",   32'(rf_we),       32'd0);
    check_eq("rw_retired", 32'(retired_cnt), 32'd0);
    check_eq("rw_errs",    {30'd0, timeout_err, illegal_err}, 32'd0);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hCAFE;
    #2;
    check_eq("rw_post_rf_we", 32'(rf_we),   32'd0);
    check_eq("rw_post_req",   32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b0;
    #2;
    check_eq("rw_post_retired", 32'(retired_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
